// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT path and its request arbiter.
package ntt_pkg;

   localparam int unsigned KYBER_N = 256;
   localparam int unsigned KYBER_Q = 3329;

   typedef logic signed [15:0] coeff_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } ntt_arb_state_e;

endpackage

// File: rtl/ntt_arb_pick.sv
// Combinational requester selector: scans requests starting at the pointer
// and returns a one-hot grant plus its index. A pointer tied to zero gives
// plain lowest-index-first priority.
module ntt_arb_pick #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_REQ-1:0] gnt_c_o,
   output logic [PW-1:0]    idx_c_o,
   output logic             any_c_o
);

   logic [PW:0]   sum;
   logic [PW-1:0] cand;

   // Rotating first-hit search, modulo N_REQ
   always_comb begin
      gnt_c_o = '0;
      idx_c_o = '0;
      any_c_o = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(i);
         if (sum >= (PW+1)'(N_REQ)) begin
            sum = sum - (PW+1)'(N_REQ);
         end
         cand = sum[PW-1:0];
         if (!any_c_o && req_i[cand]) begin
            gnt_c_o[cand] = 1'b1;
            idx_c_o       = cand;
            any_c_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ntt_arbiter.sv
// Time-shares one streaming ntt core between N_REQ requesters: grants one,
// streams its COEFF_N coefficients into the core, then returns the COEFF_N
// results to it. Define NTT_ARB_RR_EN for round-robin selection; otherwise
// the lowest requesting index wins.
module ntt_arbiter
   import ntt_pkg::*;
#(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned COEFF_N = 256,
   parameter int unsigned DW      = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [N_REQ-1:0]    i_req,
   input  logic [N_REQ-1:0]    i_req_intt,
   input  logic [N_REQ*DW-1:0] i_req_data,
   output logic [N_REQ-1:0]    o_gnt,
   output logic [N_REQ-1:0]    o_ld,
   output logic [N_REQ-1:0]    o_rsp_valid,
   output logic [DW-1:0]       o_rsp_data,
   output logic [N_REQ-1:0]    o_done,
   output logic                o_busy,
   output logic                o_err,
   output logic                o_core_ready,
   output logic                o_core_intt,
   output logic [DW-1:0]       o_core_data,
   input  logic                i_core_valid,
   input  logic [DW-1:0]       i_core_data
);

   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CW = $clog2(COEFF_N);
   localparam logic [CW-1:0] CNT_LAST = CW'(COEFF_N - 1);

   ntt_arb_state_e state_q, state_d;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    w_q, w_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             intt_q, intt_d;
   logic [DW-1:0]    core_data_q, core_data_d;
   logic             core_ready_q, core_ready_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] pick_gnt_c;
   logic [PW-1:0]    pick_idx_c;
   logic             pick_any_c;
   logic [PW-1:0]    pick_ptr_c;
   logic [DW-1:0]    req_sel_c;

   ntt_arb_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .req_i   (i_req),
      .ptr_i   (pick_ptr_c),
      .gnt_c_o (pick_gnt_c),
      .idx_c_o (pick_idx_c),
      .any_c_o (pick_any_c)
   );

`ifdef NTT_ARB_RR_EN
   logic [PW-1:0] ptr_q, ptr_d;

   // Pointer advances past the winner on every grant
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_IDLE && pick_any_c) begin
         ptr_d = (pick_idx_c == PW'(N_REQ - 1)) ? '0 : pick_idx_c + PW'(1);
      end
   end

   // Round-robin pointer register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign pick_ptr_c = ptr_q;
`else
   assign pick_ptr_c = '0;
`endif

   // Coefficient of the current winner
   always_comb begin
      req_sel_c = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (w_q == PW'(k)) begin
            req_sel_c = i_req_data[k*DW +: DW];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: grant, COEFF_N load beats, COEFF_N result beats
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_any_c) state_d = ST_LOAD;
         ST_LOAD:  if (cnt_q == CNT_LAST) state_d = ST_DRAIN;
         ST_DRAIN: if (i_core_valid && cnt_q == CNT_LAST) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      cnt_d        = cnt_q;
      w_d          = w_q;
      gnt_d        = gnt_q;
      intt_d       = intt_q;
      core_data_d  = core_data_q;
      core_ready_d = 1'b0;
      rsp_data_d   = rsp_data_q;
      rsp_valid_d  = '0;
      done_d       = '0;
      // Core output is only expected while draining; anything else is dropped
      err_d        = err_q | (i_core_valid && state_q != ST_DRAIN);
      case (state_q)
         ST_IDLE: begin
            if (pick_any_c) begin
               gnt_d  = pick_gnt_c;
               w_d    = pick_idx_c;
               intt_d = i_req_intt[pick_idx_c];
               cnt_d  = '0;
            end
         end
         ST_LOAD: begin
            core_data_d  = req_sel_c;
            core_ready_d = 1'b1;
            cnt_d        = cnt_q + CW'(1);
         end
         ST_DRAIN: begin
            if (i_core_valid) begin
               rsp_data_d  = i_core_data;
               rsp_valid_d = gnt_q;
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  done_d = gnt_q;
                  gnt_d  = '0;
                  intt_d = 1'b0;
               end
            end
         end
         default: begin
            gnt_d  = '0;
            intt_d = 1'b0;
         end
      endcase
      // Busy covers the done cycle so it falls the cycle after the pulse
      busy_d = (state_d != ST_IDLE) || (done_d != '0);
   end

   // Registered outputs and datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q        <= '0;
         w_q          <= '0;
         gnt_q        <= '0;
         intt_q       <= 1'b0;
         core_data_q  <= '0;
         core_ready_q <= 1'b0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= '0;
         done_q       <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         w_q          <= w_d;
         gnt_q        <= gnt_d;
         intt_q       <= intt_d;
         core_data_q  <= core_data_d;
         core_ready_q <= core_ready_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid_q  <= rsp_valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   // Load strobe follows the state so the requester sees it in the same cycle
   assign o_ld         = (state_q == ST_LOAD) ? gnt_q : '0;
   assign o_gnt        = gnt_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_done       = done_q;
   assign o_busy       = busy_q;
   assign o_err        = err_q;
   assign o_core_ready = core_ready_q;
   assign o_core_intt  = intt_q;
   assign o_core_data  = core_data_q;

endmodule
